hazard_scoreboard: RTL

Issue-stage RAW interlock for the in-order RISC pipeline. Keeps one countdown counter per architectural register, armed when an RF-writing instruction issues. Stalls issue while any source of the instruction at decode is still in flight. Sits between decode and the execute-stage pipeline register; its stall output freezes fetch/decode.

---
 rtl/risc_pkg.sv | 21 ++
 rtl/sb_counter.sv | 30 +++
 rtl/hazard_scoreboard.sv | 78 +++++++
 3 files changed

// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared ISA constants and opcode class decode for the in-order pipeline
// Used by the control unit and the issue-stage hazard scoreboard.
package risc_pkg;

  localparam int NREGS = 32;
  localparam int RW    = 5;
  localparam int OPW   = 6;

  typedef logic [RW-1:0]  reg_idx_t;
  typedef logic [OPW-1:0] opcode_t;

  localparam opcode_t OP_NOP    = 6'd0;
  localparam opcode_t OP_STORE  = 6'd3;
  localparam opcode_t OP_RF_MAX = 6'd20;

  // Opcodes 1..OP_RF_MAX write the register file, except stores; above that are branches.
  function automatic logic writes_rf(input opcode_t op);
    return (op != OP_NOP) && (op <= OP_RF_MAX) && (op != OP_STORE);
  endfunction

endpackage

// File: rtl/sb_counter.sv
// rtl/sb_counter.sv - per-register write-back countdown for the hazard scoreboard
// Load has priority over the decrement; the value idles at zero.
module sb_counter #(
  parameter int CW        = 3,
  parameter int LOAD_VAL  = 4,
  parameter int READY_MAX = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_ready,
  output logic o_nonzero
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(LOAD_VAL);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_ready   = (r_cnt <= CW'(READY_MAX));
  assign o_nonzero = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - issue-stage RAW interlock with one countdown per architectural register
// HAZARD_FWD_EN: sources count as ready once their counter reaches FWD_DIST (forwarding path).
module hazard_scoreboard
  import risc_pkg::*;
#(
  parameter int WB_LAT   = 4,
  parameter int FWD_DIST = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           issue_valid,
  input  logic [OPW-1:0] issue_op,
  input  logic [RW-1:0]  issue_rd,
  input  logic [RW-1:0]  issue_rs1,
  input  logic [RW-1:0]  issue_rs2,
  input  logic [1:0]     issue_rs_en,
  output logic           stall,
  output logic           issue_fire,
  output logic           busy_any,
  output logic [15:0]    stall_cycles
);

  localparam int CW = $clog2(WB_LAT + 1);
`ifdef HAZARD_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif
  localparam int READY_MAX = FWD_EN ? FWD_DIST : 0;

  logic [NREGS-1:0] w_ready;
  logic [NREGS-1:0] w_nonzero;
  logic             w_rs1_hazard;
  logic             w_rs2_hazard;
  logic             w_rf_write;
  logic [15:0]      r_stall_cycles;

  // r0 is hardwired zero: never armed, always ready.
  assign w_ready[0]   = 1'b1;
  assign w_nonzero[0] = 1'b0;

  genvar g;
  generate
    for (g = 1; g < NREGS; g++) begin : g_cnt
      sb_counter #(
        .CW        (CW),
        .LOAD_VAL  (WB_LAT),
        .READY_MAX (READY_MAX)
      ) u_cnt (
        .clk       (clk),
        .rst_n     (reset),
        .i_load    (w_rf_write && (issue_rd == RW'(g))),
        .o_ready   (w_ready[g]),
        .o_nonzero (w_nonzero[g])
      );
    end
  endgenerate

  // Hazard uses the pre-update counters, so a producer may read its own rd.
  assign w_rs1_hazard = issue_rs_en[0] && !w_ready[issue_rs1];
  assign w_rs2_hazard = issue_rs_en[1] && !w_ready[issue_rs2];

  assign stall      = issue_valid && (w_rs1_hazard || w_rs2_hazard);
  assign issue_fire = issue_valid && !stall;
  assign w_rf_write = issue_fire && writes_rf(issue_op) && (issue_rd != '0);
  assign busy_any   = |w_nonzero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= '0;
    end else if (stall && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule
